// File: rtl/game_pkg.sv
// Shared game types: operand codes and equation-builder state codes.
// Used by the equation accumulator, the HUD and the collision logic.
package game_pkg;

  // Latched operand, also shown on the HUD (00 none, 01 plus, 10 minus).
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_PLUS  = 2'b01,
    OP_MINUS = 2'b10
  } op_t;

  // Equation builder phase, exported to the HUD as-is.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXP_OP  = 2'b01,
    EXP_NUM = 2'b10,
    CHECK   = 2'b11
  } eq_state_t;

  // Decode operand hit pulses; PLUS (bit0) wins when both are set.
  function automatic op_t op_from_hit(input logic [1:0] hit);
    op_t op;
    if (hit[0]) begin
      op = OP_PLUS;
    end else if (hit[1]) begin
      op = OP_MINUS;
    end else begin
      op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/equation_accumulator_sat_alu.sv
// sat_alu: combinational saturating add/subtract.
// Ports:
//   a_i      accumulator operand (ACC_W)
//   b_i      number value, zero-extended to ACC_W (VAL_W)
//   op_i     operation; OP_NONE passes a_i through
//   result_o clamped result (ACC_W)
//   sat_o    set when the true result fell outside 0..2^ACC_W-1
module sat_alu
  import game_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int VAL_W = 4
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [VAL_W-1:0] b_i,
  input  op_t              op_i,
  output logic [ACC_W-1:0] result_o,
  output logic             sat_o
);

  logic [ACC_W-1:0] b_ext_s;
  logic [ACC_W:0]   sum_s;

  assign b_ext_s = ACC_W'(b_i);
  // One extra bit so the carry out reveals overflow; a sum of exactly max does not carry.
  assign sum_s   = {1'b0, a_i} + {1'b0, b_ext_s};

  // Select and clamp the result for the requested operation.
  always_comb begin
    result_o = a_i;
    sat_o    = 1'b0;
    case (op_i)
      OP_PLUS: begin
        if (sum_s[ACC_W]) begin
          result_o = {ACC_W{1'b1}};
          sat_o    = 1'b1;
        end else begin
          result_o = sum_s[ACC_W-1:0];
        end
      end
      OP_MINUS: begin
        // Equal operands give exactly zero and are not a saturation.
        if (b_ext_s > a_i) begin
          result_o = {ACC_W{1'b0}};
          sat_o    = 1'b1;
        end else begin
          result_o = a_i - b_ext_s;
        end
      end
      default: begin
        result_o = a_i;
        sat_o    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/equation_accumulator.sv
// equation_accumulator: builds "num op num [op num ...]" from collision hit pulses,
// evaluates it with saturating arithmetic and compares it to the level target.
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   startOfFrame           frame-start pulse, re-arms the one-event-per-frame gate
//   gameRestart            synchronous clear of all state, beats any hit
//   numberHit/numberValues hit pulses and values of the number objects
//   operandHit             bit0 PLUS, bit1 MINUS hit pulses
//   targetValue            level target, compared in CHECK
//   accValue, pendingOp    running result and latched operand
//   phase, numberHide      HUD state code and consumed-object mask
//   targetReached, arithErr one-cycle registered pulses
//   score                  saturating count of reached targets
module equation_accumulator
  import game_pkg::*;
#(
  parameter int NUMBERS = 3,
  parameter int VAL_W   = 4,
  parameter int ACC_W   = 8,
  parameter int SCORE_W = 8
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic                     gameRestart,
  input  logic [NUMBERS-1:0]       numberHit,
  input  logic [NUMBERS*VAL_W-1:0] numberValues,
  input  logic [1:0]               operandHit,
  input  logic [ACC_W-1:0]         targetValue,
  output logic [ACC_W-1:0]         accValue,
  output logic [1:0]               pendingOp,
  output logic [1:0]               phase,
  output logic [NUMBERS-1:0]       numberHide,
  output logic                     targetReached,
  output logic                     arithErr,
  output logic [SCORE_W-1:0]       score
);

  eq_state_t          state_q, state_d;
  op_t                pend_op_q, pend_op_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [NUMBERS-1:0] hide_q, hide_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               accept_flag_q, accept_flag_d;
  logic               tr_q, tr_d;
  logic               err_q, err_d;

  logic [NUMBERS-1:0] num_cand_s;
  logic [NUMBERS-1:0] num_onehot_s;
  logic               num_valid_s;
  logic [VAL_W-1:0]   num_val_s;
  logic               op_valid_s;
  op_t                op_sel_s;
  logic               can_accept_s;
  logic               accepted_s;
  logic [ACC_W-1:0]   alu_result_s;
  logic               alu_sat_s;

  // Hits on already-consumed objects never count, not even towards the frame gate.
  assign num_cand_s   = numberHit & ~hide_q;
  assign op_valid_s   = |operandHit;
  assign op_sel_s     = op_from_hit(operandHit);
  // A startOfFrame in the same cycle as a hit re-arms the gate before the hit is judged.
  assign can_accept_s = ~accept_flag_q | startOfFrame;

  // Lowest-index visible number hit; scanning downwards lets the lowest index win.
  always_comb begin
    num_valid_s  = 1'b0;
    num_onehot_s = {NUMBERS{1'b0}};
    num_val_s    = {VAL_W{1'b0}};
    for (int i = NUMBERS - 1; i >= 0; i--) begin
      if (num_cand_s[i]) begin
        num_valid_s     = 1'b1;
        num_onehot_s    = {NUMBERS{1'b0}};
        num_onehot_s[i] = 1'b1;
        num_val_s       = numberValues[i*VAL_W +: VAL_W];
      end else begin
        num_valid_s = num_valid_s;
      end
    end
  end

  sat_alu #(
    .ACC_W (ACC_W),
    .VAL_W (VAL_W)
  ) u_sat_alu (
    .a_i      (acc_q),
    .b_i      (num_val_s),
    .op_i     (pend_op_q),
    .result_o (alu_result_s),
    .sat_o    (alu_sat_s)
  );

  // Next-state and datapath updates; each state only reacts to the event kind it expects.
  always_comb begin
    state_d    = state_q;
    pend_op_d  = pend_op_q;
    acc_d      = acc_q;
    hide_d     = hide_q;
    score_d    = score_q;
    tr_d       = 1'b0;
    err_d      = 1'b0;
    accepted_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_accept_s && num_valid_s) begin
          acc_d      = ACC_W'(num_val_s);
          hide_d     = hide_q | num_onehot_s;
          state_d    = EXP_OP;
          accepted_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      EXP_OP: begin
        if (can_accept_s && op_valid_s) begin
          pend_op_d  = op_sel_s;
          state_d    = EXP_NUM;
          accepted_s = 1'b1;
        end else begin
          state_d = EXP_OP;
        end
      end
      EXP_NUM: begin
        if (can_accept_s && num_valid_s) begin
          acc_d      = alu_result_s;
          err_d      = alu_sat_s;
          hide_d     = hide_q | num_onehot_s;
          pend_op_d  = OP_NONE;
          state_d    = CHECK;
          accepted_s = 1'b1;
        end else begin
          state_d = EXP_NUM;
        end
      end
      CHECK: begin
        // Objects reappear after every evaluation; a miss keeps the chain going.
        hide_d = {NUMBERS{1'b0}};
        if (acc_q == targetValue) begin
          tr_d    = 1'b1;
          acc_d   = {ACC_W{1'b0}};
          state_d = IDLE;
          if (score_q == {SCORE_W{1'b1}}) begin
            score_d = score_q;
          end else begin
            score_d = score_q + SCORE_W'(1);
          end
        end else begin
          state_d = EXP_OP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accepted_s) begin
      accept_flag_d = 1'b1;
    end else if (startOfFrame) begin
      accept_flag_d = 1'b0;
    end else begin
      accept_flag_d = accept_flag_q;
    end
  end

  // State registers: async reset, gameRestart clears everything and wins over hits.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      pend_op_q     <= OP_NONE;
      acc_q         <= {ACC_W{1'b0}};
      hide_q        <= {NUMBERS{1'b0}};
      score_q       <= {SCORE_W{1'b0}};
      accept_flag_q <= 1'b0;
      tr_q          <= 1'b0;
      err_q         <= 1'b0;
    end else if (gameRestart) begin
      state_q       <= IDLE;
      pend_op_q     <= OP_NONE;
      acc_q         <= {ACC_W{1'b0}};
      hide_q        <= {NUMBERS{1'b0}};
      score_q       <= {SCORE_W{1'b0}};
      accept_flag_q <= 1'b0;
      tr_q          <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_op_q     <= pend_op_d;
      acc_q         <= acc_d;
      hide_q        <= hide_d;
      score_q       <= score_d;
      accept_flag_q <= accept_flag_d;
      tr_q          <= tr_d;
      err_q         <= err_d;
    end
  end

  assign accValue      = acc_q;
  assign pendingOp     = pend_op_q;
  assign phase         = state_q;
  assign numberHide    = hide_q;
  assign targetReached = tr_q;
  assign arithErr      = err_q;
  assign score         = score_q;

endmodule

// File: tb/tb_equation_accumulator.sv
// Self-checking bench for equation_accumulator: a directed vector table, hand-written
// multi-cycle sequences (saturation chains, score limit, async reset) and a random
// phase, all cross-checked against an arithmetic reference model of the game rules.
module tb_equation_accumulator;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        gameRestart;
  logic [2:0]  numberHit;
  logic [11:0] numberValues;
  logic [1:0]  operandHit;
  logic [7:0]  targetValue;
  logic [7:0]  accValue;
  logic [1:0]  pendingOp;
  logic [1:0]  phase;
  logic [2:0]  numberHide;
  logic        targetReached;
  logic        arithErr;
  logic [7:0]  score;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase 0 idle, 1 wants operand, 2 wants number, 3 check.
  int       m_phase, m_acc, m_op, m_score, m_tr, m_err;
  bit [2:0] m_hide;
  bit       m_flag;

  equation_accumulator #(
    .NUMBERS (3),
    .VAL_W   (4),
    .ACC_W   (8),
    .SCORE_W (8)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .gameRestart   (gameRestart),
    .numberHit     (numberHit),
    .numberValues  (numberValues),
    .operandHit    (operandHit),
    .targetValue   (targetValue),
    .accValue      (accValue),
    .pendingOp     (pendingOp),
    .phase         (phase),
    .numberHide    (numberHide),
    .targetReached (targetReached),
    .arithErr      (arithErr),
    .score         (score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_acc = 0; m_op = 0; m_score = 0; m_tr = 0; m_err = 0;
    m_hide = 3'b000; m_flag = 1'b0;
  endtask

  function automatic int obj_val(input int i);
    logic [11:0] v;
    v = numberValues;
    return int'(v[i*4 +: 4]);
  endfunction

  // Apply the game rules to the inputs present before the coming clock edge.
  task automatic model_step();
    int idx;
    int r;
    bit took;
    took = 1'b0;
    m_tr = 0;
    m_err = 0;
    if (gameRestart) begin
      model_reset();
    end else begin
      idx = -1;
      for (int i = 0; i < 3; i++)
        if (idx < 0 && numberHit[i] && !m_hide[i]) idx = i;
      if (m_phase == 3) begin
        m_hide = 3'b000;
        if (m_acc == int'(targetValue)) begin
          m_tr = 1;
          m_acc = 0;
          m_phase = 0;
          m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
        end else begin
          m_phase = 1;
        end
      end else if (!m_flag || startOfFrame) begin
        if (m_phase == 0 && idx >= 0) begin
          m_acc = obj_val(idx);
          m_hide[idx] = 1'b1;
          m_phase = 1;
          took = 1'b1;
        end else if (m_phase == 1 && operandHit != 2'b00) begin
          m_op = operandHit[0] ? 1 : 2;
          m_phase = 2;
          took = 1'b1;
        end else if (m_phase == 2 && idx >= 0) begin
          r = (m_op == 1) ? m_acc + obj_val(idx) : m_acc - obj_val(idx);
          if (r > 255) begin r = 255; m_err = 1; end
          if (r < 0) begin r = 0; m_err = 1; end
          m_acc = r;
          m_op = 0;
          m_hide[idx] = 1'b1;
          m_phase = 3;
          took = 1'b1;
        end
      end
      if (took) m_flag = 1'b1;
      else if (startOfFrame) m_flag = 1'b0;
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_acc"}, int'(accValue), m_acc);
    chk({tag, "_pendOp"}, int'(pendingOp), m_op);
    chk({tag, "_phase"}, int'(phase), m_phase);
    chk({tag, "_hide"}, int'(numberHide), int'(m_hide));
    chk({tag, "_targetReached"}, int'(targetReached), m_tr);
    chk({tag, "_arithErr"}, int'(arithErr), m_err);
    chk({tag, "_score"}, int'(score), m_score);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    cmp_model(tag);
  endtask

  task automatic ev(input string tag, input logic [2:0] nh, input logic [1:0] oh);
    startOfFrame = 1'b1; numberHit = nh; operandHit = oh;
    tick(tag);
    startOfFrame = 1'b0; numberHit = 3'b000; operandHit = 2'b00;
  endtask

  task automatic restart();
    gameRestart = 1'b1;
    tick("restart");
    gameRestart = 1'b0;
  endtask

  // Build accValue up from first_val with 16 additions of 15 (objects: 0=first, 1=15, 2=9).
  task automatic chain_to(input logic [3:0] first_val);
    restart();
    numberValues = {4'd9, 4'd15, first_val};
    targetValue = 8'd1;
    ev("chain_first", 3'b001, 2'b00);
    for (int k = 0; k < 16; k++) begin
      ev("chain_op", 3'b000, 2'b01);
      ev("chain_num", 3'b010, 2'b00);
      tick("chain_check");
    end
    ev("chain_lastop", 3'b000, 2'b01);
    ev("chain_last", 3'b100, 2'b00);
  endtask

  typedef struct {
    logic        sof;
    logic        rst;
    logic [2:0]  nh;
    logic [1:0]  oh;
    logic [11:0] vals;
    logic [7:0]  tgt;
    int          acc;
    int          pend;
    int          ph;
    int          hide;
    int          tr;
    int          err;
    int          sc;
  } vec_t;

  function automatic vec_t mk(input logic sof, input logic rst, input logic [2:0] nh,
                              input logic [1:0] oh, input logic [11:0] vals, input logic [7:0] tgt,
                              input int acc, input int pend, input int ph, input int hide,
                              input int tr, input int err, input int sc);
    vec_t v;
    v.sof = sof; v.rst = rst; v.nh = nh; v.oh = oh; v.vals = vals; v.tgt = tgt;
    v.acc = acc; v.pend = pend; v.ph = ph; v.hide = hide; v.tr = tr; v.err = err; v.sc = sc;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [11:0] va, vb, vc;
    string t;
    va = {4'd7, 4'd5, 4'd3};
    vb = {4'd7, 4'd5, 4'd2};
    vc = {4'd7, 4'd7, 4'd2};
    //                 sof   rst   nh      oh     vals tgt    acc pend ph hide tr err sc
    tbl.push_back(mk(1'b0, 1'b0, 3'b001, 2'b00, va, 8'd8,  3, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1'b0, 1'b0, 3'b000, 2'b00, va, 8'd8,  3, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b000, 2'b01, va, 8'd8,  3, 1, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 2'b00, va, 8'd8,  8, 0, 3, 3, 0, 0, 0));
    tbl.push_back(mk(1'b0, 1'b0, 3'b000, 2'b00, va, 8'd8,  0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b000, 2'b00, va, 8'd8,  0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 2'b00, vb, 8'd8,  2, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b000, 2'b01, vb, 8'd8,  2, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b000, 2'b10, vb, 8'd8,  2, 2, 2, 1, 0, 0, 1));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 2'b00, vc, 8'd8,  0, 0, 3, 3, 0, 1, 1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b000, 2'b00, vc, 8'd8,  0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1'b0, 1'b1, 3'b001, 2'b01, va, 8'd8,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b110, 2'b00, va, 8'd9,  5, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b000, 2'b01, va, 8'd9,  5, 1, 2, 2, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b010, 2'b00, va, 8'd9,  5, 1, 2, 2, 0, 0, 0));
    tbl.push_back(mk(1'b0, 1'b0, 3'b001, 2'b00, va, 8'd9,  8, 0, 3, 3, 0, 0, 0));
    tbl.push_back(mk(1'b0, 1'b0, 3'b000, 2'b00, va, 8'd9,  8, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 2'b11, va, 8'd9,  8, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b100, 2'b00, va, 8'd15, 15, 0, 3, 4, 0, 0, 0));
    tbl.push_back(mk(1'b1, 1'b0, 3'b001, 2'b01, va, 8'd15, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1'b0, 1'b0, 3'b010, 2'b01, va, 8'd15, 5, 0, 1, 2, 0, 0, 1));

    resetN = 1'b0; startOfFrame = 1'b0; gameRestart = 1'b0;
    numberHit = 3'b000; operandHit = 2'b00; numberValues = 12'h000; targetValue = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    #1;
    cmp_model("reset");

    // Directed vector table.
    for (int i = 0; i < tbl.size(); i++) begin
      startOfFrame = tbl[i].sof; gameRestart = tbl[i].rst; numberHit = tbl[i].nh;
      operandHit = tbl[i].oh; numberValues = tbl[i].vals; targetValue = tbl[i].tgt;
      t = $sformatf("tbl%0d", i);
      tick(t);
      chk({t, "_acc_exp"}, int'(accValue), tbl[i].acc);
      chk({t, "_pend_exp"}, int'(pendingOp), tbl[i].pend);
      chk({t, "_phase_exp"}, int'(phase), tbl[i].ph);
      chk({t, "_hide_exp"}, int'(numberHide), tbl[i].hide);
      chk({t, "_tr_exp"}, int'(targetReached), tbl[i].tr);
      chk({t, "_err_exp"}, int'(arithErr), tbl[i].err);
      chk({t, "_score_exp"}, int'(score), tbl[i].sc);
    end
    startOfFrame = 1'b0; gameRestart = 1'b0; numberHit = 3'b000; operandHit = 2'b00;

    // 250 + 9 overflows to 255 with an error pulse.
    chain_to(4'd10);
    chk("ovf_acc", int'(accValue), 255);
    chk("ovf_err", int'(arithErr), 1);
    tick("ovf_check");
    chk("ovf_err_gone", int'(arithErr), 0);

    // 246 + 9 lands exactly on 255 without an error.
    chain_to(4'd6);
    chk("max_acc", int'(accValue), 255);
    chk("max_err", int'(arithErr), 0);
    tick("max_check");

    // Score saturates at all-ones.
    restart();
    numberValues = {4'd7, 4'd5, 4'd3};
    targetValue = 8'd8;
    for (int k = 0; k < 260; k++) begin
      ev("sc_n1", 3'b001, 2'b00);
      ev("sc_op", 3'b000, 2'b01);
      ev("sc_n2", 3'b010, 2'b00);
      tick("sc_check");
    end
    chk("score_sat", int'(score), 255);

    // Asynchronous reset while waiting for the second number.
    restart();
    ev("ar_n1", 3'b001, 2'b00);
    ev("ar_op", 3'b000, 2'b01);
    chk("ar_phase_before", int'(phase), 2);
    #2;
    resetN = 1'b0;
    numberHit = 3'b010;
    #1;
    model_reset();
    cmp_model("async_reset");
    @(negedge clk);
    numberHit = 3'b000;
    resetN = 1'b1;
    tick("after_reset");

    // Random traffic against the reference model.
    for (int k = 0; k < 4000; k++) begin
      startOfFrame = ($urandom_range(3) == 0);
      gameRestart  = ($urandom_range(149) == 0);
      numberHit    = ($urandom_range(2) == 0) ? 3'($urandom_range(7)) : 3'b000;
      operandHit   = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b00;
      if ($urandom_range(15) == 0) numberValues = 12'($urandom);
      targetValue  = ($urandom_range(1) == 0) ? 8'(m_acc) : 8'($urandom_range(40));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
